// File: rtl/sd_spi_card_responder.sv
`timescale 1ns/1ps
// SPI-mode SD card command responder: decodes 48-bit host command frames on an
// oversampled SPI slave port and returns R1 (+ optional 4-byte R3/R7 tail) after an NCR gap.
module sd_spi_card_responder #(
  parameter int NCR_MIN   = 1,
  parameter int NCR_MAX   = 8,
  parameter bit CHECK_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        r1_ready,
  input  logic        r1_valid,
  input  logic [7:0]  r1_data,
  input  logic        ext_en,
  input  logic [31:0] ext_data,
  output logic        crc_error,
  output logic        rsp_done,
  output logic        rsp_timeout
);

  localparam int BW = $clog2(NCR_MAX + 1);
  localparam logic [BW-1:0] NCR_MIN_C = BW'(NCR_MIN);
  localparam logic [BW-1:0] NCR_MAX_C = BW'(NCR_MAX);

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    RX     = 3'd1,
    CHECK  = 3'd2,
    NCR    = 3'd3,
    TX_R1  = 3'd4,
    TX_EXT = 3'd5
  } state_t;

  // CRC7, polynomial x^7 + x^3 + 1, zero init, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) begin
        c = c ^ 7'h09;
      end
    end
    return c;
  endfunction

  state_t         state_r;
  logic [2:0]     sclk_sync_r;
  logic [1:0]     mosi_sync_r;
  logic [1:0]     cs_sync_r;
  logic [47:0]    rx_r;
  logic [31:0]    tx_r;
  logic [5:0]     bit_cnt_r;
  logic [BW-1:0]  byte_cnt_r;
  logic           r1_held_r;
  logic [7:0]     r1_byte_r;
  logic           ext_en_r;
  logic [31:0]    ext_data_r;

  logic           sclk_rise_s;
  logic           sclk_fall_s;
  logic           mosi_s;
  logic           cs_high_s;
  logic           accept_s;
  logic           held_eff_s;
  logic [7:0]     r1_eff_s;
  logic [BW-1:0]  byte_next_s;
  logic           frame_ok_s;

  // Two-flop synchronisers; sclk gets a third stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= 3'b000;
      mosi_sync_r <= 2'b11;
      cs_sync_r   <= 2'b11;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], sclk};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      cs_sync_r   <= {cs_sync_r[0], cs_n};
    end
  end

  // Edge strobes, accept handshake and frame check
  always_comb begin
    sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    mosi_s      = mosi_sync_r[1];
    cs_high_s   = cs_sync_r[1];
    accept_s    = (state_r == NCR) && r1_ready && r1_valid;
    held_eff_s  = r1_held_r | accept_s;
    r1_eff_s    = r1_held_r ? r1_byte_r : r1_data;
    byte_next_s = (byte_cnt_r == NCR_MAX_C) ? byte_cnt_r : byte_cnt_r + 1'b1;
    frame_ok_s  = rx_r[0] && ((CHECK_CRC == 1'b0) || (crc7(rx_r[47:8]) == rx_r[7:1]));
  end

  // Main receive / respond state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HUNT;
      miso        <= 1'b1;
      cmd_valid   <= 1'b0;
      crc_error   <= 1'b0;
      rsp_done    <= 1'b0;
      rsp_timeout <= 1'b0;
      r1_ready    <= 1'b0;
      cmd_index   <= 6'd0;
      cmd_arg     <= 32'd0;
      rx_r        <= 48'd0;
      tx_r        <= 32'd0;
      bit_cnt_r   <= 6'd0;
      byte_cnt_r  <= '0;
      r1_held_r   <= 1'b0;
      r1_byte_r   <= 8'd0;
      ext_en_r    <= 1'b0;
      ext_data_r  <= 32'd0;
    end else begin
      cmd_valid   <= 1'b0;
      crc_error   <= 1'b0;
      rsp_done    <= 1'b0;
      rsp_timeout <= 1'b0;
      if (cs_high_s) begin
        state_r    <= HUNT;
        miso       <= 1'b1;
        bit_cnt_r  <= 6'd0;
        byte_cnt_r <= '0;
        r1_ready   <= 1'b0;
        r1_held_r  <= 1'b0;
      end else begin
        if (accept_s) begin
          r1_ready   <= 1'b0;
          r1_held_r  <= 1'b1;
          r1_byte_r  <= r1_data;
          ext_en_r   <= ext_en;
          ext_data_r <= ext_data;
        end
        case (state_r)
          HUNT: begin
            miso       <= 1'b1;
            byte_cnt_r <= '0;
            r1_held_r  <= 1'b0;
            if (sclk_rise_s && !mosi_s) begin
              rx_r      <= {rx_r[46:0], 1'b0};
              bit_cnt_r <= 6'd1;
              state_r   <= RX;
            end else begin
              bit_cnt_r <= 6'd0;
            end
          end
          RX: begin
            miso <= 1'b1;
            if (sclk_rise_s) begin
              rx_r      <= {rx_r[46:0], mosi_s};
              bit_cnt_r <= bit_cnt_r + 6'd1;
              // second bit is the transmission bit and must be 1
              if (bit_cnt_r == 6'd1 && !mosi_s) begin
                state_r <= HUNT;
              end else if (bit_cnt_r == 6'd47) begin
                state_r <= CHECK;
              end else begin
                state_r <= RX;
              end
            end
          end
          CHECK: begin
            bit_cnt_r  <= 6'd0;
            byte_cnt_r <= '0;
            state_r    <= NCR;
            if (frame_ok_s) begin
              cmd_valid <= 1'b1;
              cmd_index <= rx_r[45:40];
              cmd_arg   <= rx_r[39:8];
              r1_ready  <= 1'b1;
              r1_held_r <= 1'b0;
            end else begin
              crc_error <= 1'b1;
              r1_ready  <= 1'b0;
              r1_held_r <= 1'b1;
              r1_byte_r <= 8'h08;
              ext_en_r  <= 1'b0;
            end
          end
          NCR: begin
            miso <= 1'b1;
            if (sclk_rise_s) begin
              if (bit_cnt_r == 6'd7) begin
                bit_cnt_r  <= 6'd0;
                byte_cnt_r <= byte_next_s;
                // an accept on the final boundary still wins over timeout
                if (held_eff_s && byte_next_s >= NCR_MIN_C) begin
                  tx_r     <= {r1_eff_s, 24'd0};
                  r1_ready <= 1'b0;
                  state_r  <= TX_R1;
                end else if (byte_next_s == NCR_MAX_C) begin
                  rsp_timeout <= 1'b1;
                  r1_ready    <= 1'b0;
                  state_r     <= HUNT;
                end else begin
                  state_r <= NCR;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
              end
            end
          end
          TX_R1: begin
            if (sclk_fall_s) begin
              miso <= tx_r[31];
              tx_r <= {tx_r[30:0], 1'b0};
            end else if (sclk_rise_s) begin
              if (bit_cnt_r == 6'd7) begin
                bit_cnt_r <= 6'd0;
                if (ext_en_r) begin
                  tx_r    <= ext_data_r;
                  state_r <= TX_EXT;
                end else begin
                  rsp_done  <= 1'b1;
                  miso      <= 1'b1;
                  r1_held_r <= 1'b0;
                  state_r   <= HUNT;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
              end
            end
          end
          TX_EXT: begin
            if (sclk_fall_s) begin
              miso <= tx_r[31];
              tx_r <= {tx_r[30:0], 1'b0};
            end else if (sclk_rise_s) begin
              if (bit_cnt_r == 6'd31) begin
                bit_cnt_r <= 6'd0;
                rsp_done  <= 1'b1;
                miso      <= 1'b1;
                r1_held_r <= 1'b0;
                state_r   <= HUNT;
              end else begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
              end
            end
          end
          default: begin
            miso    <= 1'b1;
            state_r <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
`timescale 1ns/1ps
// Directed bench for sd_spi_card_responder: a bit-banged SPI host sends command
// frames and reads the card's response bytes, checked against hand-computed values.
module tb_sd_spi_card_responder;

  localparam int HALF = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        r1_ready;
  logic        r1_valid;
  logic [7:0]  r1_data;
  logic        ext_en;
  logic [31:0] ext_data;
  logic        crc_error;
  logic        rsp_done;
  logic        rsp_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_crc    = 0;
  int n_done   = 0;
  int n_to     = 0;
  int v0, c0, d0, t0;
  logic [7:0]  b;
  logic [47:0] frame;

  sd_spi_card_responder dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs_n        (cs_n),
    .miso        (miso),
    .cmd_valid   (cmd_valid),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .r1_ready    (r1_ready),
    .r1_valid    (r1_valid),
    .r1_data     (r1_data),
    .ext_en      (ext_en),
    .ext_data    (ext_data),
    .crc_error   (crc_error),
    .rsp_done    (rsp_done),
    .rsp_timeout (rsp_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (cmd_valid)   n_valid <= n_valid + 1;
    if (crc_error)   n_crc   <= n_crc + 1;
    if (rsp_done)    n_done  <= n_done + 1;
    if (rsp_timeout) n_to    <= n_to + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #HALF;
      sclk = 1'b1;
      rx[i] = miso;
      #HALF;
      sclk = 1'b0;
    end
    mosi = 1'b1;
  endtask

  task automatic send_bit(input logic bv);
    mosi = bv;
    #HALF;
    sclk = 1'b1;
    #HALF;
    sclk = 1'b0;
    mosi = 1'b1;
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      xfer(f[47-8*k -: 8], d);
    end
  endtask

  task automatic read_expect(input string tag, input logic [63:0] expv, input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      xfer(8'hFF, d);
      check($sformatf("%s_byte%0d", tag, k), {24'd0, d}, {24'd0, expv[8*(n-1-k) +: 8]});
    end
  endtask

  task automatic snap();
    v0 = n_valid; c0 = n_crc; d0 = n_done; t0 = n_to;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b1; cs_n = 1'b1;
    r1_valid = 1'b0; r1_data = 8'h00; ext_en = 1'b0; ext_data = 32'h0;
    repeat (5) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd1);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
    check("rst_cmd_index", {26'd0, cmd_index}, 32'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);
    check("rst_pulses", {29'd0, crc_error, rsp_done, rsp_timeout}, 32'd0);
    rst = 1'b0;
    cs_n = 1'b0;
    repeat (5) @(negedge clk);

    // CMD0 with R1 0x01
    snap();
    r1_valid = 1'b1; r1_data = 8'h01; ext_en = 1'b0;
    send_frame(48'h40_0000_0000_95);
    read_expect("cmd0_rsp", 64'hFF01, 2);
    repeat (10) @(negedge clk);
    check("cmd0_valid", n_valid - v0, 32'd1);
    check("cmd0_index", {26'd0, cmd_index}, 32'd0);
    check("cmd0_arg", cmd_arg, 32'd0);
    check("cmd0_done", n_done - d0, 32'd1);
    check("cmd0_miso_idle", {31'd0, miso}, 32'd1);

    // CMD8 with R7 tail
    snap();
    r1_data = 8'h01; ext_en = 1'b1; ext_data = 32'h0000_01AA;
    send_frame(48'h48_0000_01AA_87);
    read_expect("cmd8_rsp", 64'hFF01_0000_01AA, 6);
    repeat (10) @(negedge clk);
    check("cmd8_valid", n_valid - v0, 32'd1);
    check("cmd8_index", {26'd0, cmd_index}, 32'd8);
    check("cmd8_arg", cmd_arg, 32'h0000_01AA);
    check("cmd8_done", n_done - d0, 32'd1);
    ext_en = 1'b0;

    // Bad CRC: card answers 0x08 on its own
    snap();
    r1_valid = 1'b0;
    send_frame(48'h40_0000_0000_97);
    read_expect("badcrc_rsp", 64'hFF08, 2);
    repeat (10) @(negedge clk);
    check("badcrc_crc_error", n_crc - c0, 32'd1);
    check("badcrc_no_valid", n_valid - v0, 32'd0);
    check("badcrc_index_held", {26'd0, cmd_index}, 32'd8);
    check("badcrc_done", n_done - d0, 32'd1);

    // Leading idle byte plus three unaligned 1-bits
    snap();
    r1_valid = 1'b1; r1_data = 8'h01;
    xfer(8'hFF, b);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    send_frame(48'h40_0000_0000_95);
    read_expect("idle_rsp", 64'hFF01, 2);
    repeat (10) @(negedge clk);
    check("idle_valid", n_valid - v0, 32'd1);
    check("idle_index", {26'd0, cmd_index}, 32'd0);

    // No R1 offered: 8 FF bytes then timeout, line stays high
    snap();
    r1_valid = 1'b0;
    send_frame(48'h40_0000_0000_95);
    for (int k = 0; k < 10; k++) begin
      xfer(8'hFF, b);
      check($sformatf("timeout_byte%0d", k), {24'd0, b}, 32'h0000_00FF);
    end
    repeat (10) @(negedge clk);
    check("timeout_pulse", n_to - t0, 32'd1);
    check("timeout_no_done", n_done - d0, 32'd0);
    check("timeout_r1_ready", {31'd0, r1_ready}, 32'd0);
    snap();
    r1_valid = 1'b1; r1_data = 8'h01;
    send_frame(48'h40_0000_0000_95);
    read_expect("after_timeout_rsp", 64'hFF01, 2);
    repeat (10) @(negedge clk);
    check("after_timeout_valid", n_valid - v0, 32'd1);

    // cs_n abort after 20 frame bits
    snap();
    frame = 48'h48_0000_01AA_87;
    for (int i = 47; i >= 28; i--) begin
      send_bit(frame[i]);
    end
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_miso", {31'd0, miso}, 32'd1);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_pulses", (n_valid - v0) + (n_crc - c0) + (n_done - d0) + (n_to - t0), 32'd0);
    send_frame(48'h40_0000_0000_95);
    read_expect("abort_rsp", 64'hFF01, 2);
    repeat (10) @(negedge clk);
    check("abort_valid", n_valid - v0, 32'd1);
    check("abort_crc", n_crc - c0, 32'd0);

    // Reset while R1 (0x00) is being shifted out
    r1_valid = 1'b1; r1_data = 8'h00; ext_en = 1'b0;
    send_frame(48'h48_0000_01AA_87);
    xfer(8'hFF, b);
    check("rsttx_ncr_byte", {24'd0, b}, 32'h0000_00FF);
    repeat (6) @(negedge clk);
    check("rsttx_first_bit", {31'd0, miso}, 32'd0);
    check("rsttx_index_before", {26'd0, cmd_index}, 32'd8);
    rst = 1'b1;
    @(negedge clk);
    check("rsttx_miso", {31'd0, miso}, 32'd1);
    check("rsttx_index", {26'd0, cmd_index}, 32'd0);
    check("rsttx_arg", cmd_arg, 32'd0);
    check("rsttx_r1_ready", {31'd0, r1_ready}, 32'd0);
    check("rsttx_pulses", {28'd0, cmd_valid, crc_error, rsp_done, rsp_timeout}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
